// File: rtl/axis_snooper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_snooper_pkg
// Description : Shared state encoding and width helper for the stream snooper
// Revision    : 1.0 - initial release
// ============================================================================
package axis_snooper_pkg;

  // Snooper state encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ARMED = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;
  localparam logic [1:0] c_ST_DROP  = 2'd3;

  // Ceiling log2 for parameter elaboration; clog2(1) is 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    for (v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_snooper_keep_popcount.sv
`default_nettype none
// ============================================================================
// Module      : keep_popcount
// Description : Counts the set bits of an AXI-Stream tkeep vector
// Revision    : 1.0 - initial release
// ============================================================================
module keep_popcount #(
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic [KEEP_WIDTH-1:0] i_keep,
  output logic [CNT_WIDTH-1:0]  o_count
);

  // Plain ones count; tkeep is contiguous but counting all bits is simpler and exact
  always_comb begin
    o_count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      o_count = o_count + CNT_WIDTH'(i_keep[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_snooper.sv
`default_nettype none
// ============================================================================
// Module      : axis_snooper
// Description : Passive AXI-Stream tap that copies whole packets into claimed
//               packet buffers and counts packets it could not capture
// Revision    : 1.0 - initial release
// ============================================================================
module axis_snooper
  import axis_snooper_pkg::*;
#(
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int INC_WIDTH         = clog2(SN_FWD_DATA_WIDTH / 8) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   tap_tdata,
  input  logic [SN_FWD_DATA_WIDTH/8-1:0] tap_tkeep,
  input  logic                           tap_tvalid,
  input  logic                           tap_tready,
  input  logic                           tap_tlast,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0]   sn_wr_data,
  output logic                           sn_wr_en,
  output logic [INC_WIDTH-1:0]           sn_byte_inc,
  output logic                           sn_done,
  input  logic                           rdy_for_sn,
  output logic                           rdy_for_sn_ack,
  output logic [31:0]                    drop_cnt
);

  localparam int KEEP_WIDTH = SN_FWD_DATA_WIDTH / 8;

  logic [1:0]                   r_state;
  logic                         r_mid;        // inside a packet on the tap
  logic                         r_held;       // a buffer is claimed and not yet completed
  logic                         r_done_pend;  // tlast written, done goes out next cycle
  logic                         r_done;
  logic                         r_ack;
  logic [SN_FWD_ADDR_WIDTH:0]   r_wr_ptr;     // next word address; MSB set means buffer full
  logic                         r_wr_en;
  logic [SN_FWD_ADDR_WIDTH-1:0] r_addr;
  logic [SN_FWD_DATA_WIDTH-1:0] r_data;
  logic [INC_WIDTH-1:0]         r_inc;
  logic [31:0]                  r_drop_cnt;

  logic                         w_beat;
  logic                         w_ack;
  logic                         w_first;
  logic                         w_wr_fire;
  logic                         w_done_fire;
  logic [SN_FWD_ADDR_WIDTH-1:0] w_wr_addr;
  logic [INC_WIDTH-1:0]         w_keep_cnt;

  keep_popcount #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .CNT_WIDTH  (INC_WIDTH)
  ) u_keep_popcount (
    .i_keep  (tap_tkeep),
    .o_count (w_keep_cnt)
  );

  // A buffer may be claimed only when none is held and no done pulse is about to go out
  assign w_beat      = tap_tvalid & tap_tready;
  assign w_ack       = rdy_for_sn & ~r_held & ~r_done_pend;
  assign w_first     = (r_state == c_ST_ARMED) & ~r_mid;
  assign w_wr_fire   = w_beat & (w_first | ((r_state == c_ST_WRITE) & ~r_wr_ptr[SN_FWD_ADDR_WIDTH]));
  assign w_done_fire = w_beat & tap_tlast & (w_first | (r_state == c_ST_WRITE));
  assign w_wr_addr   = w_first ? '0 : r_wr_ptr[SN_FWD_ADDR_WIDTH-1:0];

  // Packet tracking, buffer claim and drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_mid       <= 1'b0;
      r_held      <= 1'b0;
      r_done_pend <= 1'b0;
      r_done      <= 1'b0;
      r_ack       <= 1'b0;
      r_wr_ptr    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_ack       <= w_ack;
      r_done      <= r_done_pend;
      r_done_pend <= w_done_fire;
      if (w_ack) begin
        r_held <= 1'b1;
      end
      if (w_beat) begin
        r_mid <= ~tap_tlast;
      end
      if (w_wr_fire) begin
        r_wr_ptr <= w_first ? (SN_FWD_ADDR_WIDTH + 1)'(1) : r_wr_ptr + 1'b1;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (w_beat && !r_mid) begin
            // Packet start with no buffer to put it in
            if (r_drop_cnt != 32'hFFFF_FFFF) begin
              r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (tap_tlast) begin
              r_state <= w_ack ? c_ST_ARMED : c_ST_IDLE;
            end else begin
              r_state <= c_ST_DROP;
            end
          end else if (w_ack) begin
            r_state <= c_ST_ARMED;
          end
        end
        c_ST_ARMED: begin
          if (w_beat) begin
            if (!r_mid) begin
              r_state <= tap_tlast ? c_ST_IDLE : c_ST_WRITE;
            end else if (!tap_tlast) begin
              // Claimed mid-packet: skip the tail, keep the buffer
              r_state <= c_ST_DROP;
            end
          end
        end
        c_ST_WRITE: begin
          if (w_beat && tap_tlast) begin
            r_state <= c_ST_IDLE;
          end
        end
        c_ST_DROP: begin
          if (w_beat && tap_tlast) begin
            r_state <= (r_held || w_ack) ? c_ST_ARMED : c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
      if (w_done_fire) begin
        r_held <= 1'b0;
      end
    end
  end

  // Registered buffer write port, one cycle behind the tap beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_inc   <= '0;
    end else begin
      r_wr_en <= w_wr_fire;
      if (w_wr_fire) begin
        r_addr <= w_wr_addr;
        r_data <= tap_tdata;
        r_inc  <= w_keep_cnt;
      end
    end
  end

  assign sn_addr        = r_addr;
  assign sn_wr_data     = r_data;
  assign sn_wr_en       = r_wr_en;
  assign sn_byte_inc    = r_inc;
  assign sn_done        = r_done;
  assign rdy_for_sn_ack = r_ack;
  assign drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire
